// File: rtl/alarm_timer_pkg.sv
// Shared encodings, parameter defaults and clock constants for the alarm countdown timer.
// The ALARM_TIMER_FAST_SIM_EN macro (used by alarm_timer) selects FAST_SIM_DIV instead of CLK_HZ.
package alarm_timer_pkg;

    typedef enum logic [1:0] {
        SEL_ARM_DELAY       = 2'b00,
        SEL_DRIVER_DELAY    = 2'b01,
        SEL_PASSENGER_DELAY = 2'b10,
        SEL_ALARM_ON        = 2'b11
    } interval_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_e;

    localparam int NUM_PARAMS = 4;
    localparam int PARAM_W    = 4;

    localparam logic [PARAM_W-1:0] T_ARM_DELAY_DEF       = 4'd6;
    localparam logic [PARAM_W-1:0] T_DRIVER_DELAY_DEF    = 4'd8;
    localparam logic [PARAM_W-1:0] T_PASSENGER_DELAY_DEF = 4'd15;
    localparam logic [PARAM_W-1:0] T_ALARM_ON_DEF        = 4'd10;

    localparam int CLK_HZ       = 27_000_000;
    localparam int FAST_SIM_DIV = 4;

    function automatic logic [PARAM_W-1:0] param_default(input logic [1:0] idx);
        logic [PARAM_W-1:0] value;
        value = T_ARM_DELAY_DEF;
        case (interval_e'(idx))
            SEL_ARM_DELAY:       value = T_ARM_DELAY_DEF;
            SEL_DRIVER_DELAY:    value = T_DRIVER_DELAY_DEF;
            SEL_PASSENGER_DELAY: value = T_PASSENGER_DELAY_DEF;
            SEL_ALARM_ON:        value = T_ALARM_ON_DEF;
            default:             value = T_ARM_DELAY_DEF;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/alarm_timer_divider.sv
// Restartable modulo-DIV tick generator: one_hz_enable is high while the count sits at DIV-1.
module alarm_timer_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic one_hz_enable
);
    import alarm_timer_pkg::*;

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign one_hz_enable = (cnt_q == LAST);

endmodule

// File: rtl/alarm_timer.sv
// Alarm countdown timer: four programmable second delays, a one-second divider and an IDLE/COUNT FSM.
// Define ALARM_TIMER_FAST_SIM_EN to tick every FAST_SIM_DIV clocks instead of every CLK_HZ clocks.
module alarm_timer #(
    parameter int CLK_HZ = alarm_timer_pkg::CLK_HZ
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_timer,
    input  logic [1:0] interval,
    input  logic       reprogram,
    input  logic [1:0] time_param_sel,
    input  logic [3:0] time_value,
    output logic       expired,
    output logic [3:0] count,
    output logic       busy
);
    import alarm_timer_pkg::*;

`ifdef ALARM_TIMER_FAST_SIM_EN
    localparam int DIV = FAST_SIM_DIV;
`else
    localparam int DIV = CLK_HZ;
`endif

    logic                one_hz_enable;
    logic [PARAM_W-1:0]  param_q [NUM_PARAMS];
    logic [NUM_PARAMS-1:0] wr_en;
    logic [PARAM_W-1:0]  sel_value;

    state_e              state_q,     state_d;
    logic [PARAM_W-1:0]  count_q,     count_d;
    logic                expired_q,   expired_d;
    logic                zero_pend_q, zero_pend_d;

    alarm_timer_divider #(
        .DIV (DIV)
    ) u_divider (
        .clk           (clk),
        .reset         (reset),
        .restart       (start_timer),
        .one_hz_enable (one_hz_enable)
    );

    for (genvar gi = 0; gi < NUM_PARAMS; gi++) begin : g_wr_en
        assign wr_en[gi] = reprogram && (time_param_sel == 2'(gi));
    end

    // Read before the write lands, so a same-edge start sees the old value.
    assign sel_value = param_q[interval];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                param_q[i] <= param_default(2'(i));
            end
        end else begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                if (wr_en[i]) begin
                    param_q[i] <= time_value;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        expired_d   = zero_pend_q;
        zero_pend_d = 1'b0;

        if (start_timer) begin
            count_d = sel_value;
            if (sel_value == '0) begin
                // Nothing to count: stay idle and report completion next cycle.
                state_d     = ST_IDLE;
                zero_pend_d = 1'b1;
            end else begin
                state_d = ST_COUNT;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_COUNT: begin
                    if (one_hz_enable) begin
                        if (count_q <= PARAM_W'(1)) begin
                            count_d   = '0;
                            expired_d = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            count_d = count_q - PARAM_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            expired_q   <= 1'b0;
            zero_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            expired_q   <= expired_d;
            zero_pend_q <= zero_pend_d;
        end
    end

    assign expired = expired_q;
    assign count   = count_q;
    assign busy    = (state_q == ST_COUNT);

endmodule
